// File: rtl/inst_mem_fetch.sv
// Instruction memory with a valid/ready fetch channel and a 2-entry response buffer.
// Requests are read from a synchronous word memory one cycle after acceptance and
// the result lands in an in-order FIFO whose head drives the response channel.
// Misaligned or out-of-range requests produce a faulted response (data 0) in order.
// A flush input discards buffered and in-flight responses; a load port writes the store.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// the producer holds valid and payload stable until that edge, and ready may depend
// combinationally on the other side (req_ready depends on rsp_ready by design).
module inst_mem_fetch #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-2:0] req_idx;
    logic [ADDR_W-2:0] ld_idx;
    logic              req_in_range;
    logic              ld_in_range;
    logic              req_fault;
    logic              accept;
    logic              pop;
    logic              unused_ld_bit;

    // read stage: result of the memory access issued at the previous accept
    logic              inflight;
    logic              rd_fault;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] new_data;

    // response FIFO, entry 0 is the head
    logic [1:0]        occ;
    logic [DATA_W-1:0] e0_data, e1_data;
    logic              e0_fault, e1_fault;

    assign req_idx       = req_addr[ADDR_W-1:1];
    assign ld_idx        = ld_addr[ADDR_W-1:1];
    assign unused_ld_bit = ld_addr[0];

    // Range check only needs the index bits above the memory address width.
    generate
        if (AW < ADDR_W - 1) begin : g_range
            assign req_in_range = (req_idx[ADDR_W-2:AW] == '0);
            assign ld_in_range  = (ld_idx[ADDR_W-2:AW] == '0);
        end else begin : g_full
            assign req_in_range = 1'b1;
            assign ld_in_range  = 1'b1;
        end
    endgenerate

    assign req_fault = req_addr[0] || !req_in_range;
    assign pop       = rsp_valid && rsp_ready;
    // occ + inflight counts reserved slots; a same-cycle pop frees one.
    assign req_ready = !flush && !ld_en && reset_n &&
                       (((occ + {1'b0, inflight}) < 2'd2) || pop);
    assign accept    = req_valid && req_ready;
    assign new_data  = rd_fault ? '0 : rd_data;

    assign rsp_valid = (occ != 2'd0);
    assign rsp_data  = e0_data;
    assign rsp_fault = e0_fault;

    // Memory array: program-load writes and fetch reads (never in the same cycle).
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range)
            mem[ld_idx[AW-1:0]] <= ld_data;
        if (accept && !req_fault)
            rd_data <= mem[req_idx[AW-1:0]];
    end

    // Read-stage tracking and the in-order response FIFO; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
            rd_fault <= 1'b0;
            occ      <= 2'd0;
            e0_data  <= '0;
            e0_fault <= 1'b0;
            e1_data  <= '0;
            e1_fault <= 1'b0;
        end else if (flush) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            e0_data  <= '0;
            e0_fault <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept)
                rd_fault <= req_fault;
            if (inflight && pop) begin
                if (occ == 2'd1) begin
                    e0_data  <= new_data;
                    e0_fault <= rd_fault;
                end else begin
                    e0_data  <= e1_data;
                    e0_fault <= e1_fault;
                    e1_data  <= new_data;
                    e1_fault <= rd_fault;
                end
            end else if (pop) begin
                e0_data  <= e1_data;
                e0_fault <= e1_fault;
                occ      <= occ - 2'd1;
            end else if (inflight) begin
                if (occ == 2'd0) begin
                    e0_data  <= new_data;
                    e0_fault <= rd_fault;
                end else begin
                    e1_data  <= new_data;
                    e1_fault <= rd_fault;
                end
                occ <= occ + 2'd1;
            end
        end
    end

endmodule
